// File: rtl/row_mem_pkg.sv
// Shared types and constants for the row memory responder: state encoding,
// default widths and the power-up contents of the 8-row matrix store.
package row_mem_pkg;

  localparam int unsigned DATA_W_DEF = 64;
  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned DEPTH_DEF  = 8;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } state_t;

  // Row i byte j holds 8*i+j+1; byte 0 sits in the most significant lane.
  localparam logic [63:0] ROW_INIT [DEPTH_DEF] = '{
    64'h0102030405060708, 64'h090A0B0C0D0E0F10,
    64'h1112131415161718, 64'h191A1B1C1D1E1F20,
    64'h2122232425262728, 64'h292A2B2C2D2E2F30,
    64'h3132333435363738, 64'h393A3B3C3D3E3F40
  };

endpackage

// File: rtl/row_mem_responder_resp_pipe.sv
// Read-response delay line: LATENCY valid+data stages plus an output register,
// so a read captured at edge N is presented in the cycle after edge N+LATENCY.
module resp_pipe #(
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned LATENCY = 2
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data
);

  logic [LATENCY-1:0] stage_valid;
  logic [DATA_W-1:0]  stage_data [LATENCY];

  always_ff @(posedge clk) begin
    if (clr) begin
      stage_valid <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
    end else begin
      stage_valid[0] <= in_valid;
      stage_data[0]  <= in_data;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        stage_valid[i] <= stage_valid[i-1];
        stage_data[i]  <= stage_data[i-1];
      end
      out_valid <= stage_valid[LATENCY-1];
      out_data  <= stage_valid[LATENCY-1] ? stage_data[LATENCY-1] : '0;
    end
  end

endmodule

// File: rtl/row_mem_responder.sv
// Avalon-MM-style row store slave with fixed read latency and back-pressure.
// Optional macro RESP_STALL_EN adds a one-cycle stall after every 4th read.
module row_mem_responder
  import row_mem_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned DEPTH    = DEPTH_DEF,
  parameter int unsigned LATENCY  = 2,
  parameter int unsigned MAX_PEND = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] address,
  input  logic              read,
  input  logic              write,
  input  logic [DATA_W-1:0] writedata,
  output logic [DATA_W-1:0] readdata,
  output logic              readdatavalid,
  output logic              waitrequest
);

  localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned PEND_W = $clog2(MAX_PEND + 1);

  state_t            state;
  logic [IDX_W-1:0]  init_cnt;
  logic [PEND_W-1:0] pending;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              stall;
  logic              read_acc;
  logic              write_acc;
  logic              in_range;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] rdata;

`ifdef RESP_STALL_EN
  logic [1:0] stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      stall     <= 1'b0;
    end else begin
      stall <= read_acc && (stall_cnt == 2'd3);
      if (read_acc) stall_cnt <= stall_cnt + 2'd1;
    end
  end
`else
  assign stall = 1'b0;
`endif

  // Built only from registers so masters never see a loop through read/write.
  assign waitrequest = (state == INIT) || (pending == PEND_W'(MAX_PEND)) || stall;
  assign read_acc    = read && !waitrequest;
  assign write_acc   = write && !waitrequest;
  assign in_range    = address < ADDR_W'(DEPTH);
  assign idx         = address[IDX_W-1:0];
  assign rdata       = in_range ? mem[idx] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= INIT;
      init_cnt <= '0;
    end else if (state == INIT) begin
      if (init_cnt == IDX_W'(DEPTH - 1)) state <= READY;
      else init_cnt <= init_cnt + IDX_W'(1);
    end
  end

  // Contents are not reset directly; the INIT sweep reloads every row.
  always_ff @(posedge clk) begin
    if (!rst && state == INIT) mem[init_cnt] <= DATA_W'(ROW_INIT[init_cnt]);
    else if (!rst && write_acc && in_range) mem[idx] <= writedata;
  end

  always_ff @(posedge clk) begin
    if (rst) pending <= '0;
    else if (read_acc && !readdatavalid) pending <= pending + PEND_W'(1);
    else if (!read_acc && readdatavalid) pending <= pending - PEND_W'(1);
  end

  resp_pipe #(
    .DATA_W  (DATA_W),
    .LATENCY (LATENCY)
  ) u_resp_pipe (
    .clk       (clk),
    .clr       (rst),
    .in_valid  (read_acc),
    .in_data   (rdata),
    .out_valid (readdatavalid),
    .out_data  (readdata)
  );

endmodule
